// File: rtl/cic_interp_var.sv
// cic_interp_var: CIC interpolator, fixed or variable power-of-two rate R,
// differential delay 1. The comb section runs once per input request. The
// integrator section runs once per high-rate tick, and the two are joined by
// zero-stuffing. The output is normalised by R^(STAGES-1) using a shift.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   interpolation       rate R (used when INTERPOLATION < 0)
//   interpolation_set   synchronous clear, pulse after changing R
//   tick                high-rate enable (ticks >= 2 clocks apart)
//   in_req              one-clock request for the next in_data sample
//   in_data             signed input, valid during the in_req cycle
//   out_strobe          one-clock pulse, out_data just updated
//   out_data            signed normalised output
module cic_interp_var #(
  parameter int STAGES        = 5,
  parameter int INTERPOLATION = -8192,
  parameter int IN_WIDTH      = 16,
  parameter int GROWTH        = 52,
  parameter int OUT_WIDTH     = 16,
  parameter int MD            = 18
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [MD-1:0]               interpolation,
  input  logic                        interpolation_set,
  input  logic                        tick,
  output logic                        in_req,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_strobe,
  output logic signed [OUT_WIDTH-1:0] out_data
);

  localparam int ACC_WIDTH = IN_WIDTH + GROWTH;
  localparam int RMAX      = (INTERPOLATION < 0) ? -INTERPOLATION : INTERPOLATION;
  // Floor log2 of RMAX, which is also capped so that 1<<j still fits in MD bits.
  localparam int LG_FLOOR  = $clog2(RMAX + 1) - 1;
  localparam int LG_MAX    = (LG_FLOOR > MD - 1) ? MD - 1 : LG_FLOOR;
  localparam int SW        = 16;

  // Rate decode. Any R that is not a supported power of two falls back to
  // bypass (R=1). rmask is R-1, and s is the normalisation shift.
  logic [MD-1:0] r_sel, rmask;
  logic [SW-1:0] s;
  logic          bypass;

  always_comb begin
    r_sel  = (INTERPOLATION > 0) ? MD'(INTERPOLATION) : interpolation;
    rmask  = '0;
    s      = '0;
    bypass = 1'b1;
    for (int j = 1; j <= LG_MAX; j++) begin
      if (r_sel == (MD'(1) << j)) begin
        rmask  = (MD'(1) << j) - MD'(1);
        s      = SW'((STAGES - 1) * j);
        bypass = 1'b0;
      end
    end
  end

  logic [MD-1:0]                      phase;
  logic [STAGES-1:0][ACC_WIDTH-1:0]   dly;
  logic [STAGES:0][ACC_WIDTH-1:0]     c;
  logic [ACC_WIDTH-1:0]               comb_out;
  logic                               stuff;
  logic [STAGES-1:0][ACC_WIDTH-1:0]   integ, integ_nxt;
  logic [OUT_WIDTH-1:0]               byp_data;
  logic [OUT_WIDTH-1:0]               norm;

  // The comb chain is combinational. dly[k] holds the previous input of stage k+1.
  always_comb begin
    c[0] = {{GROWTH{in_data[IN_WIDTH-1]}}, in_data};
    for (int k = 0; k < STAGES; k++)
      c[k+1] = c[k] - dly[k];
  end

  // Each integrator adds the old value of its predecessor, which gives a
  // pipelined cascade. Only the first stage sees the zero-stuffed comb output.
  always_comb begin
    integ_nxt[0] = integ[0] + (stuff ? comb_out : '0);
    for (int k = 1; k < STAGES; k++)
      integ_nxt[k] = integ[k] + integ[k-1];
  end

  // Take bits [IN_WIDTH-1+s -: OUT_WIDTH] of the final integrator's new value.
  // No rounding is applied. The modular accumulator keeps these bits exact.
  assign norm = OUT_WIDTH'(integ_nxt[STAGES-1] >> (SW'(IN_WIDTH - OUT_WIDTH) + s));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase      <= '0;
      dly        <= '0;
      comb_out   <= '0;
      stuff      <= 1'b0;
      integ      <= '0;
      byp_data   <= '0;
      in_req     <= 1'b0;
      out_strobe <= 1'b0;
      out_data   <= '0;
    end else if (interpolation_set) begin
      phase      <= '0;
      dly        <= '0;
      comb_out   <= '0;
      stuff      <= 1'b0;
      integ      <= '0;
      byp_data   <= '0;
      in_req     <= 1'b0;
      out_strobe <= 1'b0;
      out_data   <= '0;
    end else begin
      in_req     <= tick && (phase == '0);
      out_strobe <= tick;
      if (tick) begin
        phase    <= (phase == rmask) ? '0 : phase + MD'(1);
        integ    <= integ_nxt;
        stuff    <= 1'b0;
        out_data <= bypass ? byp_data : norm;
      end
      // Tick spacing guarantees that in_req never coincides with a tick.
      if (in_req) begin
        for (int k = 0; k < STAGES; k++)
          dly[k] <= c[k];
        comb_out <= c[STAGES];
        stuff    <= 1'b1;
        byp_data <= in_data[IN_WIDTH-1 -: OUT_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_cic_interp_var.sv
module tb_cic_interp_var;
  localparam int N = 5;

  logic               clock = 1'b0;
  logic               reset;
  logic [17:0]        interpolation;
  logic               interpolation_set, tick, in_req, out_strobe;
  logic signed [15:0] in_data, out_data;

  always #5 clock = ~clock;

  cic_interp_var #(.STAGES(N), .INTERPOLATION(-8192), .IN_WIDTH(16), .GROWTH(52),
                   .OUT_WIDTH(16), .MD(18)) dut (
    .clock(clock), .reset(reset), .interpolation(interpolation),
    .interpolation_set(interpolation_set), .tick(tick), .in_req(in_req),
    .in_data(in_data), .out_strobe(out_strobe), .out_data(out_data));

  int n_tests = 0, n_fail = 0;

  // Reference model: direct convolution of the zero-stuffed input with the
  // CIC impulse response (boxcar of length R convolved N times), delayed 5 ticks.
  longint             exp_q[$];
  int                 m_r, m_s, m_t, h_len;
  longint             h[0:255];
  longint             xup[0:4095];
  logic signed [15:0] e_mon, od;

  function automatic int eff_rate(int r);
    if (r > 0 && r <= 8192 && (r & (r - 1)) == 0) return r;
    return 1;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear(int r);
    longint tmp[0:255];
    int     nl;
    m_r = eff_rate(r);
    m_s = 0;
    for (int v = m_r; v > 1; v = v / 2) m_s += N - 1;
    h[0] = 1; h_len = 1;
    for (int st = 0; st < N; st++) begin
      nl = h_len + m_r - 1;
      for (int i = 0; i < nl; i++) begin
        tmp[i] = 0;
        for (int j = 0; j < m_r; j++)
          if (i - j >= 0 && i - j < h_len) tmp[i] += h[i-j];
      end
      for (int i = 0; i < nl; i++) h[i] = tmp[i];
      h_len = nl;
    end
    m_t = 0;
    exp_q.delete();
  endtask

  task automatic model_push(logic signed [15:0] din);
    longint acc;
    logic signed [15:0] e;
    xup[m_t] = (m_t % m_r == 0) ? longint'(din) : 0;
    if (m_r == 1) e = (m_t == 0) ? 16'sd0 : 16'(xup[m_t-1]);
    else begin
      acc = 0;
      for (int k = 0; k < h_len; k++)
        if (m_t - 5 - k >= 0) acc += h[k] * xup[m_t-5-k];
      e = 16'(acc >>> m_s);
    end
    exp_q.push_back(longint'(e));
    m_t++;
  endtask

  // Scoreboard: every out_strobe consumes one expected sample.
  always @(negedge clock) begin
    if (out_strobe) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: unexpected out_strobe, out_data=%0d", out_data);
      end else begin
        e_mon = 16'(exp_q.pop_front());
        if (out_data !== e_mon) begin
          n_fail++;
          $display("FAIL scoreboard: out_data=%0d expected %0d", out_data, e_mon);
        end
      end
    end
  end

  // One tick followed by three idle clocks. Outputs are sampled on negedges.
  task automatic do_tick(input logic signed [15:0] din, output logic signed [15:0] o);
    bit exp_req;
    @(negedge clock);
    in_data = din; tick = 1'b1;
    exp_req = (m_t % m_r == 0);
    model_push(din);
    @(negedge clock);
    tick = 1'b0;
    chk("in_req", longint'(in_req), longint'(exp_req));
    chk("out_strobe", longint'(out_strobe), 1);
    o = out_data;
    @(negedge clock);
    chk("pulse_width", longint'({in_req, out_strobe}), 0);
    @(negedge clock);
  endtask

  task automatic set_rate(int r);
    @(negedge clock);
    interpolation = 18'(r); interpolation_set = 1'b1;
    @(negedge clock);
    interpolation_set = 1'b0;
    model_clear(r);
    chk("set_out_data", longint'(out_data), 0);
    chk("set_pulses", longint'({in_req, out_strobe}), 0);
  endtask

  typedef struct {
    int                 r;
    logic signed [15:0] din;
    int                 nticks;
    logic signed [15:0] exp_final;
  } vec_t;
  vec_t vt[9];
  int   exp4[16] = '{0, 0, 0, 0, 0, 1024, 5120, 10240, 10240, 5120, 1024, 0, 0, 0, 0, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1,     16'sh1234,   8,   16'sh1234};
    vt[1] = '{4,     16'sd1000,   60,  16'sd1000};
    vt[2] = '{4,     -16'sd1000,  60,  -16'sd1000};
    vt[3] = '{2,     16'sh8000,   40,  16'sh8000};
    vt[4] = '{8,     16'sd12345,  100, 16'sd12345};
    vt[5] = '{16,    -16'sd777,   120, -16'sd777};
    vt[6] = '{0,     16'sd55,     6,   16'sd55};
    vt[7] = '{3,     -16'sd7,     6,   -16'sd7};
    vt[8] = '{16384, 16'sd99,     6,   16'sd99};

    reset = 1'b1; tick = 1'b0; interpolation_set = 1'b0;
    interpolation = 18'd1; in_data = '0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_in_req", longint'(in_req), 0);
    chk("rst_out_strobe", longint'(out_strobe), 0);
    chk("rst_out_data", longint'(out_data), 0);
    reset = 1'b0;
    model_clear(1);

    // Bypass: the first tick carries the cleared capture, then the input follows.
    for (int t = 0; t < 6; t++) begin
      do_tick(16'sh1234, od);
      chk("bypass_out", longint'(od), (t == 0) ? 0 : 16'sh1234);
    end

    // Table rows: DC settling for each rate, including invalid rates (bypass).
    for (int i = 0; i < 9; i++) begin
      set_rate(vt[i].r);
      for (int t = 0; t < vt[i].nticks; t++) do_tick(vt[i].din, od);
      chk($sformatf("row%0d_final", i), longint'(od), longint'(vt[i].exp_final));
    end

    // Impulse response for R=2.
    set_rate(2);
    for (int t = 0; t < 16; t++) begin
      do_tick((t == 0) ? 16'sd16384 : 16'sd0, od);
      chk($sformatf("impulse_t%0d", t), longint'(od), exp4[t]);
    end

    // Rate change in mid-stream (R=4 to R=8).
    set_rate(4);
    for (int t = 0; t < 30; t++) do_tick(16'sd2000, od);
    set_rate(8);
    for (int t = 0; t < 60; t++) do_tick(16'sd2000, od);
    chk("r8_dc", longint'(od), 2000);

    // Async reset between a tick and its strobe.
    @(negedge clock);
    tick = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("arst_out_data", longint'(out_data), 0);
    chk("arst_pulses", longint'({in_req, out_strobe}), 0);
    @(negedge clock);
    tick = 1'b0;
    chk("arst_no_strobe", longint'(out_strobe), 0);
    @(negedge clock);
    reset = 1'b0;
    model_clear(8);
    for (int t = 0; t < 60; t++) do_tick(-16'sd3000, od);
    chk("after_rst_dc", longint'(od), -3000);

    chk("queue_empty", longint'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
